// File: rtl/ensemble_pkg.sv
// Shared definitions for the classifier-ensemble vote combiner: vote-word layout
// and a helper that assembles the vote word from its fields.
package ensemble_pkg;

    localparam int NUM_CLS_MAX   = 8;
    localparam int LABEL_LSB     = 0;
    localparam int COUNT_LSB     = 8;
    localparam int UNANIM_BIT    = 16;
    localparam int TLAST_ERR_BIT = 17;
    localparam int NEN_LSB       = 18;
    localparam int VOTE_BITS     = 24;

    // Field order mirrors the bit offsets above, MSB first.
    typedef struct packed {
        logic [5:0] nen;
        logic       tlast_err;
        logic       unanim;
        logic [7:0] count;
        logic [7:0] label;
    } vote_word_t;

    function automatic vote_word_t make_vote(
        input logic [7:0] label,
        input logic [7:0] count,
        input logic [5:0] nen,
        input logic       tlast_err
    );
        vote_word_t v;
        v.label     = label;
        v.count     = count;
        v.unanim    = (count == {2'b00, nen});
        v.tlast_err = tlast_err;
        v.nen       = nen;
        return v;
    endfunction

endpackage

// File: rtl/ensemble_vote_join_if.sv
// AXI-Stream bundle; LANES > 1 packs several independent channels side by side.
interface ensemble_vote_join_if #(
    parameter int LANES      = 1,
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = 4
);
    logic [LANES*DATA_WIDTH-1:0] tdata;
    logic [LANES*KEEP_WIDTH-1:0] tkeep;
    logic [LANES-1:0]            tvalid;
    logic [LANES-1:0]            tready;
    logic [LANES-1:0]            tlast;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ens_result_fifo.sv
// Per-channel result FIFO with the head entry visible on rd_data while not empty.
module ens_result_fifo
    import ensemble_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ensemble_vote_join.sv
// N-way classifier result combiner: buffers each channel, joins one result per
// enabled channel per sample and emits a majority-vote word on one stream.
module ensemble_vote_join
    import ensemble_pkg::*;
#(
    parameter int NUM_CLS     = 3,
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = 4,
    parameter int LABEL_WIDTH = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CLS-1:0]    en_mask,
    ensemble_vote_join_if.slave   s_axis,
    ensemble_vote_join_if.master  m_axis,
    output logic [31:0]           sample_count,
    output logic [15:0]           tlast_err_count
);
    localparam int CW = $clog2(NUM_CLS + 1);

    logic [NUM_CLS-1:0]     fifo_full;
    logic [NUM_CLS-1:0]     fifo_empty;
    logic [NUM_CLS-1:0]     fifo_wr;
    logic [NUM_CLS-1:0]     fifo_rd;
    logic [NUM_CLS-1:0]     head_last;
    logic [NUM_CLS-1:0]     ready;
    logic [LABEL_WIDTH-1:0] head_label [NUM_CLS];
    logic [CW-1:0]          match_cnt  [NUM_CLS];

    logic                   all_present;
    logic                   join_fire;
    logic [LABEL_WIDTH-1:0] win_label;
    logic [CW-1:0]          win_cnt;
    logic [5:0]             n_en;
    logic                   any_last;
    logic                   all_last;
    logic                   tlast_err;
    vote_word_t             vote;

    logic                   m_valid_reg;
    logic [DATA_WIDTH-1:0]  m_data_reg;
    logic                   m_last_reg;
    logic [31:0]            sample_count_reg;
    logic [15:0]            tlast_err_count_reg;
    logic                   unused_bits;

    // Label field plus tlast are the only parts of an input beat that matter.
    assign unused_bits = ^{s_axis.tkeep, s_axis.tdata};

    generate
        for (genvar gi = 0; gi < NUM_CLS; gi++) begin : g_ch
            logic [LABEL_WIDTH:0] rd_word;

            // Disabled channels are always ready so their sources drain harmlessly.
            assign ready[gi]   = !rst && (en_mask[gi] ? !fifo_full[gi] : 1'b1);
            assign fifo_wr[gi] = !rst && en_mask[gi] && s_axis.tvalid[gi] && !fifo_full[gi];
            assign fifo_rd[gi] = join_fire && en_mask[gi];

            ens_result_fifo #(
                .WIDTH (LABEL_WIDTH + 1),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (fifo_wr[gi]),
                .wr_data ({s_axis.tlast[gi], s_axis.tdata[gi*DATA_WIDTH +: LABEL_WIDTH]}),
                .rd_en   (fifo_rd[gi]),
                .rd_data (rd_word),
                .full    (fifo_full[gi]),
                .empty   (fifo_empty[gi])
            );

            assign head_label[gi] = rd_word[LABEL_WIDTH-1:0];
            assign head_last[gi]  = rd_word[LABEL_WIDTH];
        end
    endgenerate

    assign s_axis.tready = ready;
    assign all_present   = &(~fifo_empty | ~en_mask);
    assign join_fire     = (en_mask != '0) && all_present && (!m_valid_reg || m_axis.tready);

    always_comb begin
        for (int i = 0; i < NUM_CLS; i++) begin
            match_cnt[i] = '0;
            for (int j = 0; j < NUM_CLS; j++) begin
                if (en_mask[j] && (head_label[j] == head_label[i])) begin
                    match_cnt[i] = match_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Strict ">" plus the label tie-break yields the smallest label among equal counts.
    always_comb begin
        win_label = '0;
        win_cnt   = '0;
        n_en      = '0;
        any_last  = 1'b0;
        all_last  = 1'b1;
        for (int i = 0; i < NUM_CLS; i++) begin
            if (en_mask[i]) begin
                n_en     = n_en + 6'd1;
                any_last = any_last | head_last[i];
                all_last = all_last & head_last[i];
                if ((match_cnt[i] > win_cnt) ||
                    ((match_cnt[i] == win_cnt) && (head_label[i] < win_label))) begin
                    win_cnt   = match_cnt[i];
                    win_label = head_label[i];
                end
            end
        end
    end

    assign tlast_err = any_last && !all_last;
    assign vote      = make_vote(8'(win_label), 8'(win_cnt), n_en, tlast_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_reg         <= 1'b0;
            m_data_reg          <= '0;
            m_last_reg          <= 1'b0;
            sample_count_reg    <= '0;
            tlast_err_count_reg <= '0;
        end else begin
            if (m_valid_reg && m_axis.tready) begin
                sample_count_reg <= sample_count_reg + 32'd1;
            end
            if (join_fire) begin
                m_valid_reg <= 1'b1;
                m_data_reg  <= DATA_WIDTH'(vote);
                m_last_reg  <= any_last;
                if (tlast_err && (tlast_err_count_reg != 16'hFFFF)) begin
                    tlast_err_count_reg <= tlast_err_count_reg + 16'd1;
                end
            end else if (m_axis.tready) begin
                m_valid_reg <= 1'b0;
            end
        end
    end

    assign m_axis.tvalid   = m_valid_reg;
    assign m_axis.tdata    = m_data_reg;
    assign m_axis.tlast    = m_last_reg;
    assign m_axis.tkeep    = '1;
    assign sample_count    = sample_count_reg;
    assign tlast_err_count = tlast_err_count_reg;

endmodule

// File: tb/tb_ensemble_vote_join.sv
// Bench for ensemble_vote_join: queue-based reference model checked every cycle,
// directed scenarios with hand-computed vote words, then randomized traffic.
module tb_ensemble_vote_join;
    import ensemble_pkg::*;

    localparam int NC = 3;
    localparam int DW = 32;
    localparam int KW = 4;
    localparam int LW = 4;
    localparam int FD = 4;

    typedef struct {
        int lab;
        bit lst;
        int gap;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] en_mask;
    logic [31:0]   sample_count;
    logic [15:0]   tlast_err_count;

    ensemble_vote_join_if #(.LANES(NC), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_if ();
    ensemble_vote_join_if #(.LANES(1),  .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) m_if ();

    ensemble_vote_join #(
        .NUM_CLS(NC), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LABEL_WIDTH(LW), .FIFO_DEPTH(FD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en_mask         (en_mask),
        .s_axis          (s_if),
        .m_axis          (m_if),
        .sample_count    (sample_count),
        .tlast_err_count (tlast_err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t          mq [NC][$];
    bit            mv;
    logic [31:0]   md;
    bit            ml;
    logic [31:0]   msc;
    logic [15:0]   mec;
    bit            model_ok = 1'b0;
    logic [32:0]   out_log [$];

    function automatic logic [31:0] model_vote(input logic [NC-1:0] mask, input int lab[NC],
                                               input bit lst[NC], output bit any_l, output bit err);
        int hist[16];
        int nen, best, best_l, nl;
        nen = 0; best = 0; best_l = 0; nl = 0;
        for (int l = 0; l < 16; l++) hist[l] = 0;
        for (int i = 0; i < NC; i++) begin
            if (mask[i]) begin
                hist[lab[i]]++;
                nen++;
                if (lst[i]) nl++;
            end
        end
        for (int l = 0; l < 16; l++) begin
            if (hist[l] > best) begin
                best   = hist[l];
                best_l = l;
            end
        end
        any_l = (nl > 0);
        err   = (nl > 0) && (nl < nen);
        return (32'(best_l) << LABEL_LSB) | (32'(best) << COUNT_LSB) |
               (32'(best == nen) << UNANIM_BIT) | (32'(err) << TLAST_ERR_BIT) |
               (32'(nen) << NEN_LSB);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) mq[i].delete();
        mv = 1'b0; md = '0; ml = 1'b0; msc = '0; mec = '0;
    endtask

    always @(negedge clk) begin : cmp
        bit [NC-1:0] rdy;
        bit          fire, terr, lastv;
        int          lab [NC];
        bit          lst [NC];
        ent_t        e;
        if (!model_ok) begin
            if (rst) begin
                model_reset();
                model_ok = 1'b1;
            end
        end else begin
            for (int i = 0; i < NC; i++) begin
                rdy[i] = !rst && (!en_mask[i] || (mq[i].size() < FD));
                check($sformatf("tready%0d", i), 64'(s_if.tready[i]), 64'(rdy[i]));
            end
            check("m_tvalid", 64'(m_if.tvalid), 64'(mv));
            check("m_tdata", 64'(m_if.tdata), 64'(md));
            check("m_tlast", 64'(m_if.tlast), 64'(ml));
            check("m_tkeep", 64'(m_if.tkeep), 64'(4'hF));
            check("sample_count", 64'(sample_count), 64'(msc));
            check("tlast_err_count", 64'(tlast_err_count), 64'(mec));
            if (rst) begin
                model_reset();
            end else begin
                if (m_if.tvalid[0] && m_if.tready[0]) begin
                    out_log.push_back({m_if.tlast[0], m_if.tdata});
                    $display("vote %0d: word=%08h tlast=%0d", out_log.size() - 1, m_if.tdata, m_if.tlast);
                end
                if (mv && m_if.tready[0]) msc++;
                fire = (en_mask != '0) && (!mv || m_if.tready[0]);
                for (int i = 0; i < NC; i++) begin
                    if (en_mask[i] && (mq[i].size() == 0)) fire = 1'b0;
                end
                if (fire) begin
                    for (int i = 0; i < NC; i++) begin
                        lab[i] = 0;
                        lst[i] = 1'b0;
                        if (en_mask[i]) begin
                            e = mq[i].pop_front();
                            lab[i] = e.lab;
                            lst[i] = e.lst;
                        end
                    end
                    md = model_vote(en_mask, lab, lst, lastv, terr);
                    ml = lastv;
                    mv = 1'b1;
                    if (terr && (mec != 16'hFFFF)) mec++;
                end else if (m_if.tready[0]) begin
                    mv = 1'b0;
                end
                for (int i = 0; i < NC; i++) begin
                    if (en_mask[i] && s_if.tvalid[i] && rdy[i]) begin
                        e.lab = int'(s_if.tdata[i*DW +: LW]);
                        e.lst = s_if.tlast[i];
                        e.gap = 0;
                        mq[i].push_back(e);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    ent_t src [NC][$];
    int   hold [NC];
    int   mready_mode;

    function automatic ent_t mk(input int lab, input bit lst, input int gap);
        ent_t e;
        e.lab = lab; e.lst = lst; e.gap = gap;
        return e;
    endfunction

    task automatic step();
        logic [NC-1:0] acc;
        @(negedge clk);
        acc = s_if.tvalid & s_if.tready;
        @(posedge clk);
        #1;
        case (mready_mode)
            0:       m_if.tready = 1'b1;
            1:       m_if.tready = 1'b0;
            default: m_if.tready = 1'($urandom_range(0, 1));
        endcase
        for (int i = 0; i < NC; i++) begin
            if (acc[i]) begin
                s_if.tvalid[i] = 1'b0;
                src[i].delete(0);
            end
            if (!s_if.tvalid[i] && (src[i].size() > 0)) begin
                if (hold[i] < src[i][0].gap) begin
                    hold[i]++;
                end else begin
                    hold[i] = 0;
                    s_if.tvalid[i] = 1'b1;
                    s_if.tlast[i]  = src[i][0].lst;
                    s_if.tdata[i*DW +: DW] = ($urandom() << LW) | 32'(src[i][0].lab);
                end
            end
        end
    endtask

    function automatic bit busy();
        bit b;
        b = mv || (s_if.tvalid != '0);
        for (int i = 0; i < NC; i++) begin
            if ((src[i].size() != 0) || (mq[i].size() != 0)) b = 1'b1;
        end
        return b;
    endfunction

    task automatic drain(input string name, input int limit);
        int n;
        n = 0;
        while (busy() && (n < limit)) begin
            step();
            n++;
        end
        check(name, 64'(busy()), 64'(0));
        repeat (2) step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        logic [31:0] held_word;
        logic [31:0] sc0;
        rst          = 1'b1;
        en_mask      = '1;
        mready_mode  = 0;
        m_if.tready  = 1'b1;
        s_if.tvalid  = '0;
        s_if.tlast   = '0;
        s_if.tdata   = '0;
        s_if.tkeep   = '1;
        for (int i = 0; i < NC; i++) hold[i] = 0;

        repeat (3) step();
        check("rst_tvalid", 64'(m_if.tvalid), 64'(0));
        check("rst_tdata", 64'(m_if.tdata), 64'(0));
        check("rst_tlast", 64'(m_if.tlast), 64'(0));
        check("rst_counts", 64'({sample_count, tlast_err_count}), 64'(0));
        check("rst_tready", 64'(s_if.tready), 64'(0));
        rst = 1'b0;
        step();
        check("ready_after_rst", 64'(s_if.tready), 64'(3'b111));

        // labels 2,2,5 arrive together
        base = out_log.size();
        src[0].push_back(mk(2, 0, 0));
        src[1].push_back(mk(2, 0, 0));
        src[2].push_back(mk(5, 0, 0));
        step();
        step();
        check("t1_not_early", 64'(m_if.tvalid), 64'(0));
        step();
        check("t1_valid", 64'(m_if.tvalid), 64'(1));
        check("t1_word", 64'(m_if.tdata), 64'(32'h000C0202));
        step();
        check("t1_sample_count", 64'(sample_count), 64'(1));

        // three-way tie, then unanimous with tlast
        src[0].push_back(mk(1, 0, 0)); src[1].push_back(mk(4, 0, 0)); src[2].push_back(mk(7, 0, 0));
        src[0].push_back(mk(3, 1, 0)); src[1].push_back(mk(3, 1, 0)); src[2].push_back(mk(3, 1, 0));
        drain("t2_drain", 200);
        check("t2_tie", 64'(out_log[base+1]), 64'({1'b0, 32'h000C0101}));
        check("t2_unanim", 64'(out_log[base+2]), 64'({1'b1, 32'h000D0303}));

        // channel 2 late: channels 0/1 fill their FIFOs and stall
        base = out_log.size();
        for (int k = 0; k < 5; k++) begin
            src[0].push_back(mk(k, 0, 0));
            src[1].push_back(mk(k, 0, 0));
            src[2].push_back(mk(k + 8, 0, (k == 0) ? 12 : 0));
        end
        repeat (8) step();
        check("t3_ch0_stall", 64'(s_if.tready[0]), 64'(0));
        check("t3_ch1_stall", 64'(s_if.tready[1]), 64'(0));
        check("t3_no_output", 64'(out_log.size()), 64'(base));
        drain("t3_drain", 300);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_vote%0d", k), 64'(out_log[base+k]), 64'({1'b0, 32'h000C0200 + 32'(k)}));
        end

        // downstream stall with continuous input
        mready_mode = 1;
        base = out_log.size();
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < NC; i++) src[i].push_back(mk($urandom_range(0, 15), 0, 0));
        end
        repeat (6) step();
        check("t4_valid", 64'(m_if.tvalid), 64'(1));
        held_word = m_if.tdata;
        repeat (20) step();
        check("t4_hold_word", 64'(m_if.tdata), 64'(held_word));
        check("t4_hold_valid", 64'(m_if.tvalid), 64'(1));
        check("t4_all_stalled", 64'(s_if.tready), 64'(3'b000));
        sc0 = sample_count;
        mready_mode = 0;
        drain("t4_drain", 300);
        check("t4_count_delta", 64'(sample_count - sc0), 64'(12));
        check("t4_log_delta", 64'(out_log.size() - base), 64'(12));

        // channel 1 disabled, sends garbage
        en_mask = 3'b101;
        base = out_log.size();
        for (int k = 0; k < 20; k++) src[1].push_back(mk($urandom_range(0, 15), 1'($urandom_range(0, 1)), 0));
        for (int k = 0; k < 3; k++) begin
            src[0].push_back(mk(6, 0, 0));
            src[2].push_back(mk(6, 0, 0));
        end
        repeat (4) step();
        check("t5_ch1_ready", 64'(s_if.tready[1]), 64'(1));
        drain("t5_drain", 300);
        check("t5_vote", 64'(out_log[base]), 64'({1'b0, 32'h00090206}));
        check("t5_votes", 64'(out_log.size() - base), 64'(3));

        // tlast disagreement
        en_mask = 3'b111;
        base = out_log.size();
        check("t6_err_before", 64'(tlast_err_count), 64'(0));
        src[0].push_back(mk(0, 1, 0)); src[1].push_back(mk(0, 0, 0)); src[2].push_back(mk(0, 1, 0));
        drain("t6_drain", 200);
        check("t6_vote", 64'(out_log[base]), 64'({1'b1, 32'h000F0300}));
        check("t6_err_count", 64'(tlast_err_count), 64'(1));

        // reset with results buffered
        mready_mode = 1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NC; i++) src[i].push_back(mk(9, 0, 0));
        end
        repeat (6) step();
        check("t7_pending", 64'(m_if.tvalid), 64'(1));
        rst = 1'b1;
        step();
        check("t7_rst_valid", 64'(m_if.tvalid), 64'(0));
        check("t7_rst_counts", 64'({sample_count, tlast_err_count}), 64'(0));
        for (int i = 0; i < NC; i++) begin
            src[i].delete();
            hold[i] = 0;
        end
        s_if.tvalid = '0;
        step();
        rst = 1'b0;
        mready_mode = 0;
        base = out_log.size();
        repeat (10) step();
        check("t7_no_stale", 64'(out_log.size()), 64'(base));
        check("t7_idle_valid", 64'(m_if.tvalid), 64'(0));

        // all channels disabled: everything drains, nothing joins
        en_mask = 3'b000;
        base = out_log.size();
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < NC; i++) src[i].push_back(mk(k, 0, 0));
        end
        drain("t8_drain", 200);
        check("t8_no_votes", 64'(out_log.size()), 64'(base));

        // randomized rounds
        for (int r = 0; r < 4; r++) begin
            en_mask = NC'($urandom_range(1, 7));
            mready_mode = 2;
            base = out_log.size();
            for (int k = 0; k < 40; k++) begin
                for (int i = 0; i < NC; i++) begin
                    src[i].push_back(mk($urandom_range(0, 15), 1'($urandom_range(0, 1)), $urandom_range(0, 3)));
                end
            end
            drain($sformatf("rand%0d_drain", r), 3000);
            check($sformatf("rand%0d_votes", r), 64'(out_log.size() - base), 64'(40));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
